// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: recovers pixel coordinates from HSYNC/VSYNC, verifies
// line and frame lengths, raises a lock flag and samples the colour at a probe coordinate.
module vga_sync_decoder #(
  parameter int unsigned HDisplay   = 640,
  parameter int unsigned HFront     = 16,
  parameter int unsigned HTotal     = 800,
  parameter int unsigned VDisplay   = 480,
  parameter int unsigned VFront     = 10,
  parameter int unsigned VTotal     = 525,
  parameter int unsigned LockFrames = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hs_i,
  input  logic       vs_i,
  input  logic [5:0] rgb_i,
  input  logic [9:0] probe_x_i,
  input  logic [9:0] probe_y_i,
  output logic [9:0] pix_x_o,
  output logic [9:0] pix_y_o,
  output logic       pix_valid_o,
  output logic [5:0] rgb_o,
  output logic       locked_o,
  output logic       frame_stb_o,
  output logic [5:0] probe_rgb_o,
  output logic [7:0] err_cnt_o
);

  localparam logic [9:0]  HSyncPos    = 10'(HDisplay + HFront);
  localparam logic [9:0]  VSyncPos    = 10'(VDisplay + VFront);
  localparam logic [9:0]  HLast       = 10'(HTotal - 1);
  localparam logic [9:0]  VLast       = 10'(VTotal - 1);
  localparam logic [9:0]  HDisp       = 10'(HDisplay);
  localparam logic [9:0]  VDisp       = 10'(VDisplay);
  localparam logic [10:0] LineLenGood = 11'(HTotal);
  localparam logic [9:0]  LineCntGood = 10'(VTotal);
  localparam logic [7:0]  LockGoal    = 8'(LockFrames);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e      state_q;
  logic        s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q;
  logic [5:0]  s1_rgb_q;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic [10:0] line_len_q, line_len_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [7:0]  good_frames_q, err_cnt_q;
  logic        locked_q, frame_stb_q, pix_valid_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [5:0]  rgb_q, shadow_q, probe_rgb_q;
  logic        hs_rise, vs_rise, line_bad, frame_bad, pos_err, err_event;

  assign hs_rise = s1_hs_q & ~s2_hs_q;
  assign vs_rise = s1_vs_q & ~s2_vs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
      s1_rgb_q <= '0;
    end else begin
      s1_hs_q  <= hs_i;
      s1_vs_q  <= vs_i;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s1_rgb_q <= rgb_i;
    end
  end

  // hc/vc describe the pixel currently held in stage s1; sync edges re-align them.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == HLast) begin
      hc_d = '0;
      vc_d = (vc_q == VLast) ? '0 : vc_q + 10'd1;
    end
    if (hs_rise) hc_d = HSyncPos + 10'd1;
    if (vs_rise) begin
      vc_d = VSyncPos;
      if (!hs_rise) hc_d = 10'd1;
    end
  end

  always_comb begin
    line_len_d = hs_rise ? 11'd1 : ((line_len_q == '1) ? line_len_q : line_len_q + 11'd1);
    line_cnt_d = line_cnt_q;
    if (vs_rise) begin
      line_cnt_d = '0;
    end else if (hs_rise && line_cnt_q != '1) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end
  end

  always_comb begin
    line_bad  = hs_rise && (line_len_q != LineLenGood);
    frame_bad = vs_rise && (line_cnt_q != LineCntGood);
    pos_err   = (hs_rise && (hc_q != HSyncPos)) ||
                (vs_rise && ((vc_q != VSyncPos) || (hc_q != '0)));
    case (state_q)
      StMeasure: err_event = line_bad || frame_bad;
      StLocked:  err_event = line_bad || pos_err;
      default:   err_event = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hc_q       <= '0;
      vc_q       <= '0;
      line_len_q <= '0;
      line_cnt_q <= '0;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      line_len_q <= line_len_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  // Lock FSM; locked_q and frame_stb_q are set on the transitions so they track the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StSearch;
      good_frames_q <= '0;
      err_cnt_q     <= '0;
      locked_q      <= 1'b0;
      frame_stb_q   <= 1'b0;
    end else begin
      frame_stb_q <= 1'b0;
      if (err_event && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      case (state_q)
        StSearch: begin
          if (vs_rise) begin
            state_q       <= StMeasure;
            good_frames_q <= '0;
          end
        end
        StMeasure: begin
          if (err_event) begin
            state_q <= StSearch;
          end else if (vs_rise) begin
            good_frames_q <= good_frames_q + 8'd1;
            if (good_frames_q + 8'd1 == LockGoal) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end
        end
        StLocked: begin
          if (err_event) begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end else if (vs_rise) begin
            frame_stb_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StSearch;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
      shadow_q    <= '0;
      probe_rgb_q <= '0;
    end else begin
      pix_x_q     <= hc_q;
      pix_y_q     <= vc_q;
      rgb_q       <= s1_rgb_q;
      pix_valid_q <= (state_q == StLocked) && (hc_q < HDisp) && (vc_q < VDisp);
      if (state_q == StLocked && hc_q == probe_x_i && vc_q == probe_y_i) shadow_q <= s1_rgb_q;
      if (frame_stb_q) probe_rgb_q <= shadow_q;
    end
  end

  assign pix_x_o     = pix_x_q;
  assign pix_y_o     = pix_y_q;
  assign pix_valid_o = pix_valid_q;
  assign rgb_o       = rgb_q;
  assign locked_o    = locked_q;
  assign frame_stb_o = frame_stb_q;
  assign probe_rgb_o = probe_rgb_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled-down VGA transmitter model (24x14 total) drives the
// decoder through lock, pixel/probe tables, line/frame faults, error saturation and reset.
module tb_vga_sync_decoder;
  localparam int HD = 16, HF = 2, HT = 24, VD = 8, VF = 2, VT = 14;
  localparam int HsBeg = HD + HF, HsEnd = HD + HF + 4, VsBeg = VD + VF, VsEnd = VD + VF + 2;

  logic       clk = 1'b0, rst_n = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [5:0] rgb = '0;
  logic [9:0] probe_x = '0, probe_y = '0;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid, locked, frame_stb;
  logic [5:0] rgb_out, probe_rgb;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .HDisplay(HD), .HFront(HF), .HTotal(HT), .VDisplay(VD), .VFront(VF), .VTotal(VT),
    .LockFrames(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .hs_i(hs), .vs_i(vs), .rgb_i(rgb),
    .probe_x_i(probe_x), .probe_y_i(probe_y), .pix_x_o(pix_x), .pix_y_o(pix_y),
    .pix_valid_o(pix_valid), .rgb_o(rgb_out), .locked_o(locked), .frame_stb_o(frame_stb),
    .probe_rgb_o(probe_rgb), .err_cnt_o(err_cnt)
  );

  typedef struct {int h; int v; int x; int y; int valid; int rgb;} pix_vec_t;
  typedef struct {int px; int py; int rgb;} probe_vec_t;

  int n_checks = 0, n_errors = 0;
  int tx_h = 0, tx_v = 3, frame_lines = VT, last_h = -1, last_v = -1, stb_cnt = 0;
  bit hs_en = 1'b1, tx_on = 1'b1, short_pending = 1'b0, vs_rose = 1'b0, hs_rose = 1'b0;
  pix_vec_t   pix_tab[7];
  probe_vec_t probe_tab[4];
  int exp_short[6];
  int exp_nohs[3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  // One clock: drive the next transmitter pixel #1 after the edge, then advance it.
  task automatic step();
    logic nhs, nvs;
    @(posedge clk);
    #1;
    if (frame_stb === 1'b1) stb_cnt++;
    vs_rose = 1'b0;
    hs_rose = 1'b0;
    if (tx_on) begin
      nhs = hs_en && tx_h >= HsBeg && tx_h < HsEnd;
      nvs = tx_v >= VsBeg && tx_v < VsEnd;
      hs_rose = nhs && !hs;
      vs_rose = nvs && !vs;
      hs = nhs;
      vs = nvs;
      rgb = (tx_h >= 8 && tx_h <= 11 && tx_v >= 6 && tx_v <= 7) ? 6'b010000 : 6'b000000;
      last_h = tx_h;
      last_v = tx_v;
      if (short_pending && tx_v == 2 && tx_h == HT - 2) begin
        tx_h = 0;
        tx_v = 3;
        short_pending = 1'b0;
      end else if (tx_h == HT - 1) begin
        tx_h = 0;
        tx_v = (tx_v + 1 >= frame_lines) ? 0 : tx_v + 1;
      end else begin
        tx_h++;
      end
    end
  endtask

  task automatic wait_vs();
    int k = 0;
    do begin step(); k++; end while (!vs_rose && k < 1000);
    if (!vs_rose) timeout("wait_vs");
  endtask

  task automatic wait_stb();
    int k = 0;
    do begin step(); k++; end while (frame_stb !== 1'b1 && k < 1000);
    if (frame_stb !== 1'b1) timeout("wait_stb");
  endtask

  task automatic wait_pix(input int h, input int v);
    int k = 0;
    do begin step(); k++; end while (!(last_h == h && last_v == v) && k < 1000);
    if (!(last_h == h && last_v == v)) timeout("wait_pix");
  endtask

  task automatic wait_hs_line(input int v);
    int k = 0;
    do begin step(); k++; end while (!(hs_rose && last_v == v && !short_pending) && k < 1000);
    if (!(hs_rose && last_v == v)) timeout("wait_hs_line");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_frame_stb"}, int'(frame_stb), 0);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_pix_x"}, int'(pix_x), 0);
    check({tag, "_pix_y"}, int'(pix_y), 0);
    check({tag, "_rgb_out"}, int'(rgb_out), 0);
    check({tag, "_probe_rgb"}, int'(probe_rgb), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  task automatic toggle_vs(input int n);
    for (int i = 0; i < n; i++) begin
      vs = 1'b1; step(); step();
      vs = 1'b0; step(); step();
    end
  endtask

  task automatic lock_after_three(input string tag);
    for (int i = 1; i <= 3; i++) begin
      wait_vs();
      step();
      check({tag, "_lock_early"}, int'(locked), 0);
      step();
      check({tag, "_lock"}, int'(locked), (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected one");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pix_tab[0] = '{h: 0,  v: 0,  x: 0,  y: 0,  valid: 1, rgb: 0};
    pix_tab[1] = '{h: 8,  v: 6,  x: 8,  y: 6,  valid: 1, rgb: 16};
    pix_tab[2] = '{h: 11, v: 7,  x: 11, y: 7,  valid: 1, rgb: 16};
    pix_tab[3] = '{h: 12, v: 7,  x: 12, y: 7,  valid: 1, rgb: 0};
    pix_tab[4] = '{h: 16, v: 7,  x: 16, y: 7,  valid: 0, rgb: 0};
    pix_tab[5] = '{h: 15, v: 8,  x: 15, y: 8,  valid: 0, rgb: 0};
    pix_tab[6] = '{h: 23, v: 13, x: 23, y: 13, valid: 0, rgb: 0};
    probe_tab[0] = '{px: 9,  py: 6,  rgb: 16};
    probe_tab[1] = '{px: 20, py: 12, rgb: 0};
    probe_tab[2] = '{px: 11, py: 7,  rgb: 16};
    probe_tab[3] = '{px: 0,  py: 0,  rgb: 0};
    exp_short = '{2, 2, 3, 3, 4, 4};
    exp_nohs  = '{5, 5, 6};

    // Reset, release mid-frame, lock on the third VSYNC.
    repeat (5) step();
    check_zero("reset");
    rst_n = 1'b1;
    lock_after_three("init");
    check("init_err", int'(err_cnt), 0);

    wait_vs();
    step(); check("stb_before", int'(frame_stb), 0);
    step(); check("stb_pulse", int'(frame_stb), 1);
    step(); check("stb_after", int'(frame_stb), 0);

    foreach (pix_tab[i]) begin
      wait_pix(pix_tab[i].h, pix_tab[i].v);
      step(); step();
      check("pix_x", int'(pix_x), pix_tab[i].x);
      check("pix_y", int'(pix_y), pix_tab[i].y);
      check("pix_valid", int'(pix_valid), pix_tab[i].valid);
      check("rgb_out", int'(rgb_out), pix_tab[i].rgb);
    end

    foreach (probe_tab[i]) begin
      probe_x = 10'(probe_tab[i].px);
      probe_y = 10'(probe_tab[i].py);
      wait_stb();
      wait_stb();
      step();
      check("probe_rgb", int'(probe_rgb), probe_tab[i].rgb);
    end

    // Probe output only moves at a frame boundary.
    probe_x = 10'd8; probe_y = 10'd6;
    wait_pix(10, 6);
    repeat (3) step();
    check("probe_hold", int'(probe_rgb), 0);
    wait_stb();
    step();
    check("probe_update", int'(probe_rgb), 16);

    // One 23-cycle line while locked.
    wait_vs();
    short_pending = 1'b1;
    wait_hs_line(3);
    step(); step();
    check("short_unlock", int'(locked), 0);
    check("short_err", int'(err_cnt), 1);
    lock_after_three("relock");
    check("relock_err", int'(err_cnt), 1);

    // Frames one line short: no lock, one error per measured frame.
    wait_vs(); step(); step();
    stb_cnt = 0;
    frame_lines = VT - 1;
    for (int i = 0; i < 6; i++) begin
      wait_vs(); step(); step();
      check("short_frame_err", int'(err_cnt), exp_short[i]);
      check("short_frame_locked", int'(locked), 0);
    end

    // HSYNC absent: zero lines per frame.
    hs_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_vs(); step(); step();
      check("nohs_err", int'(err_cnt), exp_nohs[i]);
      check("nohs_locked", int'(locked), 0);
    end

    // Fast VSYNC toggling to saturate the error counter.
    tx_on = 1'b0;
    vs = 1'b0;
    step(); step();
    toggle_vs(496);
    step(); step();
    check("err_254", int'(err_cnt), 254);
    toggle_vs(2);
    step(); step();
    check("err_255", int'(err_cnt), 255);
    toggle_vs(100);
    step(); step();
    check("err_sat", int'(err_cnt), 255);
    check("sat_locked", int'(locked), 0);
    check("no_stb_unlocked", stb_cnt, 0);

    // Restore a clean stream, lock, then reset asynchronously mid-frame.
    tx_h = 0; tx_v = 0; frame_lines = VT; hs_en = 1'b1; tx_on = 1'b1;
    probe_x = 10'd9; probe_y = 10'd6;
    lock_after_three("restore");
    check("restore_err", int'(err_cnt), 255);
    wait_vs();
    repeat (3) step();
    check("pre_rst_probe", int'(probe_rgb), 16);
    wait_pix(5, 4);
    step(); step();
    check("pre_rst_pix_x", int'(pix_x), 5);
    check("pre_rst_pix_y", int'(pix_y), 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (3) step();
    rst_n = 1'b1;
    lock_after_three("post_rst");
    check("post_rst_err", int'(err_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
